mem_access_ctrl: RTL

//  MEM-stage initiator for the doubleword memory file. Takes one load/store per request, sized B/H/W/D.

---
 rtl/mem_access_ctrl.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage initiator for a doubleword-line memory.
// Takes one B/H/W/D load or store per request. Sub-doubleword stores are done
// as read-modify-write of the aligned 8-byte line. Loads return sign- or
// zero-extended data. Misaligned requests and stall timeouts are flagged.
//
// Ports:
//   CLK, reset           clock; synchronous active-high reset
//   req_valid/req_ready  request handshake (ready only in IDLE)
//   req_we/req_size/req_unsigned/req_addr/req_wdata  request fields
//   resp_valid           one-cycle completion pulse
//   resp_rdata           load result (0 for stores and errors)
//   resp_misalign        misaligned request, no memory access made
//   resp_err             aborted after stall timeout
//   MEM_V/we/address/mem_data  memory request (address is line aligned)
//   v_mem_stall          memory not ready, hold request
//   data_out             combinational line read for current address
module mem_access_ctrl #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  output logic [63:0]       resp_rdata,
  output logic              resp_misalign,
  output logic              resp_err,
  output logic              MEM_V,
  output logic              we,
  output logic [ADDR_W-1:0] address,
  output logic [63:0]       mem_data,
  input  logic              v_mem_stall,
  input  logic [63:0]       data_out
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t             state, state_next;
  logic               op_we, op_we_next;
  logic [1:0]         op_size, op_size_next;
  logic               op_unsigned, op_unsigned_next;
  logic [2:0]         op_off, op_off_next;
  logic [63:0]        op_wdata, op_wdata_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               timeout_hit;

  logic               req_ready_next;
  logic               resp_valid_next;
  logic [63:0]        resp_rdata_next;
  logic               resp_misalign_next;
  logic               resp_err_next;
  logic               mem_v_next;
  logic               we_next;
  logic [ADDR_W-1:0]  address_next;
  logic [63:0]        mem_data_next;

  // Address must be a multiple of the access size.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
    case (size)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = off[0];
      2'b10:   is_misaligned = |off[1:0];
      default: is_misaligned = |off;
    endcase
  endfunction

  // Byte-lane mask for the access size, in the low bytes.
  function automatic logic [63:0] size_mask(input logic [1:0] size);
    case (size)
      2'b00:   size_mask = 64'h0000_0000_0000_00FF;
      2'b01:   size_mask = 64'h0000_0000_0000_FFFF;
      2'b10:   size_mask = 64'h0000_0000_FFFF_FFFF;
      default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  // Pull the addressed field out of the line and extend it.
  function automatic logic [63:0] extract(input logic [63:0] line, input logic [1:0] size,
                                          input logic [2:0] off, input logic uns);
    logic [63:0] sh;
    logic        sx;
    sh = line >> {off, 3'b000};
    sx = ~uns;
    case (size)
      2'b00:   extract = {{56{sx & sh[7]}}, sh[7:0]};
      2'b01:   extract = {{48{sx & sh[15]}}, sh[15:0]};
      2'b10:   extract = {{32{sx & sh[31]}}, sh[31:0]};
      default: extract = sh;
    endcase
  endfunction

  // Replace the addressed bytes of the line with the low store bytes.
  function automatic logic [63:0] merge(input logic [63:0] line, input logic [63:0] wdata,
                                        input logic [1:0] size, input logic [2:0] off);
    logic [63:0] m;
    m = size_mask(size);
    merge = (line & ~(m << {off, 3'b000})) | ((wdata & m) << {off, 3'b000});
  endfunction

  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

  // State and registered outputs.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state         <= IDLE;
      op_we         <= 1'b0;
      op_size       <= 2'b00;
      op_unsigned   <= 1'b0;
      op_off        <= 3'b000;
      op_wdata      <= 64'h0;
      cnt           <= '0;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_rdata    <= 64'h0;
      resp_misalign <= 1'b0;
      resp_err      <= 1'b0;
      MEM_V         <= 1'b0;
      we            <= 1'b0;
      address       <= '0;
      mem_data      <= 64'h0;
    end else begin
      state         <= state_next;
      op_we         <= op_we_next;
      op_size       <= op_size_next;
      op_unsigned   <= op_unsigned_next;
      op_off        <= op_off_next;
      op_wdata      <= op_wdata_next;
      cnt           <= cnt_next;
      req_ready     <= req_ready_next;
      resp_valid    <= resp_valid_next;
      resp_rdata    <= resp_rdata_next;
      resp_misalign <= resp_misalign_next;
      resp_err      <= resp_err_next;
      MEM_V         <= mem_v_next;
      we            <= we_next;
      address       <= address_next;
      mem_data      <= mem_data_next;
    end
  end

  // Next state and next output values; outputs reflect the state being entered.
  always_comb begin
    state_next         = state;
    op_we_next         = op_we;
    op_size_next       = op_size;
    op_unsigned_next   = op_unsigned;
    op_off_next        = op_off;
    op_wdata_next      = op_wdata;
    cnt_next           = cnt;
    req_ready_next     = 1'b0;
    resp_valid_next    = 1'b0;
    resp_rdata_next    = 64'h0;
    resp_misalign_next = 1'b0;
    resp_err_next      = 1'b0;
    mem_v_next         = 1'b0;
    we_next            = 1'b0;
    address_next       = address;
    mem_data_next      = mem_data;

    case (state)
      IDLE: begin
        req_ready_next = 1'b1;
        if (req_valid) begin
          req_ready_next   = 1'b0;
          op_we_next       = req_we;
          op_size_next     = req_size;
          op_unsigned_next = req_unsigned;
          op_off_next      = req_addr[2:0];
          op_wdata_next    = req_wdata;
          if (is_misaligned(req_size, req_addr[2:0])) begin
            state_next         = RESP;
            resp_valid_next    = 1'b1;
            resp_misalign_next = 1'b1;
          end else begin
            state_next   = RD;
            mem_v_next   = 1'b1;
            address_next = {req_addr[ADDR_W-1:3], 3'b000};
            cnt_next     = '0;
          end
        end
      end

      RD: begin
        if (v_mem_stall) begin
          cnt_next = cnt + CNT_W'(1);
          if (timeout_hit) begin
            state_next      = RESP;
            resp_valid_next = 1'b1;
            resp_err_next   = 1'b1;
          end else begin
            mem_v_next = 1'b1;
          end
        end else if (op_we) begin
          state_next    = WR;
          mem_v_next    = 1'b1;
          we_next       = 1'b1;
          cnt_next      = '0;
          mem_data_next = merge(data_out, op_wdata, op_size, op_off);
        end else begin
          state_next      = RESP;
          resp_valid_next = 1'b1;
          resp_rdata_next = extract(data_out, op_size, op_off, op_unsigned);
        end
      end

      WR: begin
        if (v_mem_stall) begin
          cnt_next = cnt + CNT_W'(1);
          if (timeout_hit) begin
            // Abandoned write is not retried.
            state_next      = RESP;
            resp_valid_next = 1'b1;
            resp_err_next   = 1'b1;
          end else begin
            mem_v_next = 1'b1;
            we_next    = 1'b1;
          end
        end else begin
          state_next      = RESP;
          resp_valid_next = 1'b1;
        end
      end

      default: begin
        state_next     = IDLE;
        req_ready_next = 1'b1;
      end
    endcase
  end

endmodule
